// File: rtl/csr_wr_unit.sv
// Machine-mode CSR write unit: handshaked 4-cycle read-modify-write of the
// writable machine CSRs, returning the old value for rd write-back.
module csr_wr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [11:0] csr_adr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] src_i,
  input  logic [4:0]  zimm_i,
  input  logic        src_is_x0_i,
  input  logic        instret_inc_i,
  output logic [31:0] rd_val_o,
  output logic        done_o,
  output logic        illegal_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [1:0]  fsm_state_o
);

  // Handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both 1; req_valid_i is ignored while req_ready_o is 0.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_MODIFY = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

  localparam logic [11:0] ADR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADR_MEPC      = 12'h341;
  localparam logic [11:0] ADR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADR_MTVEC     = 12'h305;
  localparam logic [11:0] ADR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADR_INSTRETH  = 12'hC82;

  state_t      state_q, state_d;
  logic [11:0] adr_q;
  logic [1:0]  op_q;
  logic [31:0] operand_q;
  logic        suppress_q;
  logic [31:0] old_q;
  logic [31:0] new_q;
  logic        illegal_q;
  logic [31:0] rd_val_q;

  logic [31:0] mscratch_q, mepc_q, mcause_q, mtvec_q;
  logic [31:0] minstret_lo_q, minstret_hi_q;

  logic        accept;
  logic        commit;
  logic [31:0] rd_mux;
  logic        mapped;
  logic        illegal_dec;
  logic        suppress_in;

  assign accept      = req_valid_i && (state_q == ST_IDLE);
  assign req_ready_o = (state_q == ST_IDLE);
  assign done_o      = (state_q == ST_WRITE);
  assign illegal_o   = done_o && illegal_q;
  assign rd_val_o    = rd_val_q;
  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;
  assign fsm_state_o = state_q;
  assign commit      = (state_q == ST_WRITE) && !illegal_q && !suppress_q;

  // Set/clear with a zero operand is a pure read and has no side effect.
  always_comb begin
    suppress_in = 1'b0;
    if (funct3_i[1]) begin
      suppress_in = funct3_i[2] ? (zimm_i == 5'd0) : src_is_x0_i;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    mapped = 1'b1;
    case (adr_q)
      ADR_MSCRATCH:                rd_mux = mscratch_q;
      ADR_MEPC:                    rd_mux = mepc_q;
      ADR_MCAUSE:                  rd_mux = mcause_q;
      ADR_MTVEC:                   rd_mux = mtvec_q;
      ADR_MINSTRET,  ADR_INSTRET:  rd_mux = minstret_lo_q;
      ADR_MINSTRETH, ADR_INSTRETH: rd_mux = minstret_hi_q;
      default:                     mapped = 1'b0;
    endcase
    illegal_dec = !mapped || (op_q == 2'b00) ||
                  ((adr_q[11:10] == 2'b11) && !suppress_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid_i) state_d = ST_READ;
      ST_READ:   state_d = ST_MODIFY;
      ST_MODIFY: state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_q      <= 12'h0;
      op_q       <= 2'b00;
      operand_q  <= 32'h0;
      suppress_q <= 1'b0;
      old_q      <= 32'h0;
      new_q      <= 32'h0;
      illegal_q  <= 1'b0;
      rd_val_q   <= 32'h0;
    end else begin
      if (accept) begin
        adr_q      <= csr_adr_i;
        op_q       <= funct3_i[1:0];
        operand_q  <= funct3_i[2] ? {27'b0, zimm_i} : src_i;
        suppress_q <= suppress_in;
      end
      if (state_q == ST_READ) begin
        old_q     <= illegal_dec ? 32'h0 : rd_mux;
        illegal_q <= illegal_dec;
      end
      if (state_q == ST_MODIFY) begin
        rd_val_q <= old_q;
        case (op_q)
          2'b01:   new_q <= operand_q;
          2'b10:   new_q <= old_q | operand_q;
          2'b11:   new_q <= old_q & ~operand_q;
          default: new_q <= old_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
    end else if (commit) begin
      case (adr_q)
        ADR_MSCRATCH: mscratch_q <= new_q;
        ADR_MEPC:     mepc_q     <= {new_q[31:2], 2'b00};
        ADR_MCAUSE:   mcause_q   <= new_q;
        ADR_MTVEC:    mtvec_q    <= {new_q[31:2], 2'b00};
        default:      ;
      endcase
    end
  end

  // A software write to either half wins over a same-cycle retire pulse,
  // which is dropped whole (no carry into the other half).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      minstret_lo_q <= 32'h0;
      minstret_hi_q <= 32'h0;
    end else if (commit && (adr_q == ADR_MINSTRET)) begin
      minstret_lo_q <= new_q;
    end else if (commit && (adr_q == ADR_MINSTRETH)) begin
      minstret_hi_q <= new_q;
    end else if (instret_inc_i) begin
      {minstret_hi_q, minstret_lo_q} <= {minstret_hi_q, minstret_lo_q} + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_wr_unit.sv
// Bench for csr_wr_unit: scenario tasks drive requests, a negedge monitor
// pops the expected {illegal, rd_val} queue on every done_o pulse.
module tb_csr_wr_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [11:0] csr_adr_i;
  logic [2:0]  funct3_i;
  logic [31:0] src_i;
  logic [4:0]  zimm_i;
  logic        src_is_x0_i;
  logic        instret_inc_i;
  logic [31:0] rd_val_o;
  logic        done_o;
  logic        illegal_o;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic [1:0]  fsm_state_o;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  localparam logic [2:0] F_RW = 3'b001, F_RS = 3'b010, F_RC = 3'b011;
  localparam logic [2:0] F_RWI = 3'b101, F_RSI = 3'b110, F_RCI = 3'b111;

  csr_wr_unit #(.MTVEC_RESET(32'h8000_0003)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .csr_adr_i(csr_adr_i), .funct3_i(funct3_i), .src_i(src_i),
    .zimm_i(zimm_i), .src_is_x0_i(src_is_x0_i),
    .instret_inc_i(instret_inc_i), .rd_val_o(rd_val_o),
    .done_o(done_o), .illegal_o(illegal_o),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .fsm_state_o(fsm_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // scoreboard
  always @(negedge clk_i) begin
    if (done_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done_o with no request outstanding, rd_val=%h", rd_val_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({illegal_o, rd_val_o} !== e) begin
          errors++;
          $display("FAIL done_result: got illegal=%b rd_val=%h, expected illegal=%b rd_val=%h",
                   illegal_o, rd_val_o, e[32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic [11:0] adr, input logic [2:0] f3,
                      input logic [31:0] src, input logic [4:0] zimm,
                      input logic x0, input logic [31:0] exp_rd,
                      input logic exp_ill);
    int lat;
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle: req_ready_o=%b, expected 1", req_ready_o);
    end
    csr_adr_i = adr; funct3_i = f3; src_i = src; zimm_i = zimm;
    src_is_x0_i = x0; req_valid_i = 1'b1;
    exp_q.push_back({exp_ill, exp_rd});
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_busy: req_ready_o=%b, expected 0", req_ready_o);
    end
    lat = 1;
    while (done_o !== 1'b1 && lat < 8) begin
      @(negedge clk_i);
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL latency adr=%h: done after %0d cycles, expected 3", adr, lat);
    end
  endtask

  // Suppressed set with x0 source: a side-effect-free read.
  task automatic read_csr(input logic [11:0] adr, input logic [31:0] exp_rd);
    send(adr, F_RS, $urandom, $urandom_range(0, 31), 1'b1, exp_rd, 1'b0);
  endtask

  task automatic pulse_inc();
    @(negedge clk_i);
    instret_inc_i = 1'b1;
    @(negedge clk_i);
    instret_inc_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = 1'b0; csr_adr_i = '0; funct3_i = '0;
    src_i = '0; zimm_i = '0; src_is_x0_i = 1'b0; instret_inc_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({mtvec_o, mepc_o} !== {32'h8000_0000, 32'h0}) begin
      errors++;
      $display("FAIL reset_regs: mtvec=%h mepc=%h, expected 80000000 00000000", mtvec_o, mepc_o);
    end
    checks++;
    if ({req_ready_o, done_o, illegal_o, rd_val_o} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b done=%b illegal=%b rd_val=%h, expected 1 0 0 0",
               req_ready_o, done_o, illegal_o, rd_val_o);
    end
    read_csr(12'h340, 32'h0);
    read_csr(12'h342, 32'h0);
    read_csr(12'hB02, 32'h0);
    read_csr(12'hB82, 32'h0);
  endtask

  task automatic test_rmw();
    send(12'h340, F_RW,  32'hDEAD_BEEF, 5'd0,  1'b0, 32'h0,         1'b0);
    send(12'h340, F_RS,  32'h0000_00F0, 5'd0,  1'b0, 32'hDEAD_BEEF, 1'b0);
    send(12'h340, F_RCI, 32'hFFFF_FFFF, 5'h0F, 1'b0, 32'hDEAD_BEFF, 1'b0);
    read_csr(12'h340, 32'hDEAD_BEF0);
    send(12'h342, F_RWI, 32'hFFFF_FFFF, 5'h1B, 1'b1, 32'h0,         1'b0);
    send(12'h342, F_RC,  32'h0000_0003, 5'd0,  1'b0, 32'h0000_001B, 1'b0);
    send(12'h342, F_RSI, 32'h0,         5'h04, 1'b0, 32'h0000_0018, 1'b0);
    read_csr(12'h342, 32'h0000_001C);
  endtask

  task automatic test_illegal();
    send(12'hC00, F_RS, 32'h1, 5'd0, 1'b0, 32'h0, 1'b1);
    send(12'h340, 3'b000, 32'h5555_5555, 5'd0, 1'b0, 32'h0, 1'b1);
    send(12'h340, 3'b100, 32'h5555_5555, 5'h1F, 1'b0, 32'h0, 1'b1);
    send(12'hC02, F_RW, 32'h1234_0000, 5'd0, 1'b0, 32'h0, 1'b1);
    send(12'hC82, F_RSI, 32'h0, 5'h01, 1'b0, 32'h0, 1'b1);
    send(12'h7C0, F_RW, 32'h1, 5'd0, 1'b0, 32'h0, 1'b1);
    read_csr(12'hC02, 32'h0);
    send(12'h340, F_RSI, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'hDEAD_BEF0, 1'b0);
    send(12'h340, F_RC, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'hDEAD_BEF0, 1'b0);
    read_csr(12'h340, 32'hDEAD_BEF0);
  endtask

  task automatic test_mtvec();
    send(12'h305, F_RW, 32'h1000_0007, 5'd0, 1'b0, 32'h8000_0000, 1'b0);
    checks++;
    if (mtvec_o !== 32'h8000_0000) begin
      errors++;
      $display("FAIL mtvec_early: mtvec=%h in done cycle, expected 80000000", mtvec_o);
    end
    @(negedge clk_i);
    checks++;
    if (mtvec_o !== 32'h1000_0004) begin
      errors++;
      $display("FAIL mtvec_write: mtvec=%h, expected 10000004", mtvec_o);
    end
    read_csr(12'h305, 32'h1000_0004);
  endtask

  task automatic test_minstret();
    send(12'hB02, F_RW, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0, 1'b0);
    pulse_inc();
    read_csr(12'hB02, 32'h0);
    read_csr(12'hC82, 32'h1);
    send(12'hB82, F_RW, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h1, 1'b0);
    send(12'hB02, F_RW, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0, 1'b0);
    pulse_inc();
    read_csr(12'hC02, 32'h0);
    read_csr(12'hB82, 32'h0);
    pulse_inc();
    pulse_inc();
    read_csr(12'hC02, 32'h2);
  endtask

  task automatic test_collision();
    @(negedge clk_i);
    csr_adr_i = 12'hB02; funct3_i = F_RW; src_i = 32'hFFFF_FFFF;
    src_is_x0_i = 1'b0; req_valid_i = 1'b1;
    exp_q.push_back({1'b0, 32'h2});
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL collision_done: done_o=%b in WRITE cycle, expected 1", done_o);
    end
    instret_inc_i = 1'b1;
    @(negedge clk_i);
    instret_inc_i = 1'b0;
    read_csr(12'hB02, 32'hFFFF_FFFF);
    read_csr(12'hB82, 32'h0);
  endtask

  task automatic test_back_to_back();
    int gap;
    @(negedge clk_i);
    csr_adr_i = 12'h342; funct3_i = F_RW; src_i = 32'hA5A5_0001;
    src_is_x0_i = 1'b0; req_valid_i = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_001C});
    exp_q.push_back({1'b0, 32'hA5A5_0001});
    gap = 0;
    while (done_o !== 1'b1 && gap < 8) begin
      @(negedge clk_i);
      gap++;
    end
    src_i = 32'h0BAD_F00D;
    gap = 0;
    @(negedge clk_i);
    gap++;
    while (done_o !== 1'b1 && gap < 8) begin
      @(negedge clk_i);
      gap++;
    end
    req_valid_i = 1'b0;
    checks++;
    if (gap != 4) begin
      errors++;
      $display("FAIL throughput: done pulses %0d cycles apart, expected 4", gap);
    end
    read_csr(12'h342, 32'h0BAD_F00D);
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    csr_adr_i = 12'h341; funct3_i = F_RW; src_i = 32'h1234_5677;
    src_is_x0_i = 1'b0; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if ({req_ready_o, done_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_async: ready=%b done=%b, expected 1 0", req_ready_o, done_o);
    end
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, done_o, mepc_o} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid: ready=%b done=%b mepc=%h, expected 1 0 00000000",
               req_ready_o, done_o, mepc_o);
    end
    rst_i = 1'b0;
    send(12'h341, F_RW, 32'h1234_5677, 5'd0, 1'b0, 32'h0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (mepc_o !== 32'h1234_5674) begin
      errors++;
      $display("FAIL mepc_write: mepc=%h, expected 12345674", mepc_o);
    end
    read_csr(12'h340, 32'h0);
  endtask

  initial begin
    test_reset();
    test_rmw();
    test_illegal();
    test_mtvec();
    test_minstret();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
